hex_display_sequencer: RTL and testbench
========================================

Name: hex_display_sequencer

Overview:
Sequences updates of a bank of NDIGITS 7-segment PIO output registers (one Avalon PIO slave per digit, 7-bit data register at address 0) from a single packed hex value. Decodes each nibble to active-low segment codes. Skips digits whose code is unchanged. Issues one Avalon-style write per changed digit, so software or a status block can push a whole number with a single request.

Parameters:
NDIGITS, 4, number of digits / PIO slaves driven (1..8)
BLANK_CODE, 7'h7F, segment code for a blanked digit (all segments off, active-low)

Ports:
clk  in  1  system clock
reset_n  in  1  reset
req_valid  in  1  one-cycle request strobe
req_value  in  4*NDIGITS  packed nibbles; digit i = req_value[4i+3:4i], digit 0 = least significant
req_blank_lz  in  1  blank leading zeros (digit 0 never blanked)
req_force  in  1  write all digits regardless of shadow
busy  out  1  high while a request is being processed
done  out  1  one-cycle pulse after the last digit of a request
pio_chipselect  out  NDIGITS  one-hot select of target PIO
pio_write_n  out  1  active-low write strobe
pio_address  out  2  always 2'b00
pio_writedata  out  32  {25'b0, segment code}

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset values: busy=0, done=0, pio_chipselect=0, pio_write_n=1, pio_writedata=0, pending flag=0, all shadow codes=7'h00. The shadow value matches the PIO reset value, so every digit shows all segments on.
- Decode (gfedcba, bit0=a, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E (hex).
- Blanking: with req_blank_lz=1, digits from NDIGITS-1 downward whose nibble is 0 get BLANK_CODE. Blanking stops at the first nonzero nibble or at digit 0.
- State machine: IDLE, LOAD, CHECK, WRITE, DONE.
- IDLE: if pending flag set, or req_valid=1, go to LOAD. The pending request takes priority; a req_valid in the same cycle overwrites the pending slot and is served first.
- LOAD: latch value, blank and force bits; compute all codes; idx=0; busy=1.
- CHECK: if force, or code[idx] != shadow[idx], go to WRITE. Otherwise, if idx==NDIGITS-1 go to DONE, else idx+1 and stay in CHECK.
- WRITE: exactly one cycle with pio_chipselect[idx]=1, pio_write_n=0, pio_writedata={25'b0,code[idx]}; shadow[idx] updated. Next state is CHECK (idx+1) or DONE if idx==NDIGITS-1.
- DONE: done=1 for one cycle, busy=0 in the next cycle, return to IDLE.
- Outside WRITE: pio_chipselect=0 and pio_write_n=1. pio_writedata holds its last value.
- Latency: req_valid at cycle n (IDLE) -> LOAD at n+1 -> first CHECK at n+2 -> first write at n+3 if digit 0 changed.
- Worst case is 2*NDIGITS+2 cycles from LOAD to done. An unchanged value takes NDIGITS+2 cycles with zero writes.
- req_valid while busy (including the DONE cycle): the request is stored in a single pending slot and the pending flag is set. A later request overwrites it (latest wins). The current sequence is never aborted.
- Reset mid-sequence: write strobe deasserts immediately, the pending request is lost, and shadow returns to 7'h00. This is consistent with the PIOs also being reset.

Test Plan:
- After reset, req_value=16'h1234, blank=0, force=0 -> 4 writes, one per digit: digit0=0x19, digit1=0x30, digit2=0x24, digit3=0x79. Each write lasts one cycle with one-hot chipselect. done pulses at 2*4+2 cycles after LOAD.
- Repeat 16'h1234 -> zero writes; done pulses NDIGITS+2 cycles after LOAD.
- 16'h1235 after 16'h1234 -> single write to digit0 with 0x12.
- 16'h0007 with blank=1 -> digits 3,2,1 get 0x7F and digit0 gets 0x78. 16'h0000 with blank=1 -> digit0=0x40, others 0x7F.
- During a sequence, issue 16'hAAAA then 16'hBBBB -> after the current done, only 16'hBBBB is processed (writes 0x03 to each digit), followed by a second done.
- Assert reset_n low during a WRITE cycle -> pio_write_n=1 and busy=0 immediately. After release, 16'h8888 writes 0x00? No write occurs, because shadow is 0x00, so done pulses with zero writes. Then force=1 -> 4 writes.

Source files
------------

// File: rtl/hex_display_if.sv
// Request / PIO-write bundle for the hex display sequencer.
// master = requester and PIO-bus observer, slave = sequencer.
interface hex_display_if #(
    parameter int NDIGITS = 4
);
    logic                   req_valid;
    logic [4*NDIGITS-1:0]   req_value;
    logic                   req_blank_lz;
    logic                   req_force;
    logic                   busy;
    logic                   done;
    logic [NDIGITS-1:0]     pio_chipselect;
    logic                   pio_write_n;
    logic [1:0]             pio_address;
    logic [31:0]            pio_writedata;

    modport master (
        output req_valid, req_value, req_blank_lz, req_force,
        input  busy, done, pio_chipselect, pio_write_n, pio_address, pio_writedata
    );

    modport slave (
        input  req_valid, req_value, req_blank_lz, req_force,
        output busy, done, pio_chipselect, pio_write_n, pio_address, pio_writedata
    );
endinterface

// File: rtl/hex_display_sequencer.sv
// Decodes a packed hex value to 7-segment codes and writes only the changed digits
// to a bank of PIO slaves, one write per digit.
//   state | meaning
//   IDLE  | waiting for a new or pending request
//   LOAD  | latch request, decode all digits, idx = 0
//   CHECK | decide whether digit idx needs a write
//   WRITE | one-cycle PIO write of digit idx
//   DONE  | done pulse, busy drops next cycle
module hex_display_sequencer #(
    parameter int         NDIGITS    = 4,
    parameter logic [6:0] BLANK_CODE = 7'h7F
) (
    input logic           clk,
    input logic           reset_n,
    hex_display_if.slave  bus
);
    localparam int              IDXW     = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, WRITE, DONE} state_t;

    state_t               state;
    logic [4*NDIGITS-1:0] slot_value;
    logic                 slot_blank;
    logic                 slot_force;
    logic                 pending;
    logic                 cur_force;
    logic [IDXW-1:0]      idx;
    logic [6:0]           code_q    [NDIGITS];
    logic [6:0]           shadow    [NDIGITS];
    logic [6:0]           next_code [NDIGITS];
    logic                 leading;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Leading-zero blanking walks from the top digit down; digit 0 always shows.
    always_comb begin
        next_code = '{default: BLANK_CODE};
        leading   = slot_blank;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            if (leading && (i != 0) && (slot_value[4*i +: 4] == 4'h0)) begin
                next_code[i] = BLANK_CODE;
            end else begin
                next_code[i] = seg_decode(slot_value[4*i +: 4]);
                leading      = 1'b0;
            end
        end
    end

    assign bus.pio_address = 2'b00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            slot_value         <= '0;
            slot_blank         <= 1'b0;
            slot_force         <= 1'b0;
            pending            <= 1'b0;
            cur_force          <= 1'b0;
            idx                <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.pio_chipselect <= '0;
            bus.pio_write_n    <= 1'b1;
            bus.pio_writedata  <= '0;
            for (int i = 0; i < NDIGITS; i++) begin
                code_q[i] <= 7'h00;
                shadow[i] <= 7'h00;
            end
        end else begin
            bus.done           <= 1'b0;
            bus.pio_chipselect <= '0;
            bus.pio_write_n    <= 1'b1;

            // Single slot: the newest request always wins.
            if (bus.req_valid) begin
                slot_value <= bus.req_value;
                slot_blank <= bus.req_blank_lz;
                slot_force <= bus.req_force;
                if (state != IDLE) pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.req_valid || pending) begin
                        pending  <= 1'b0;
                        bus.busy <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    code_q    <= next_code;
                    cur_force <= slot_force;
                    idx       <= '0;
                    state     <= CHECK;
                end
                CHECK: begin
                    if (cur_force || (code_q[idx] != shadow[idx])) begin
                        bus.pio_chipselect <= NDIGITS'(1) << idx;
                        bus.pio_write_n    <= 1'b0;
                        bus.pio_writedata  <= {25'b0, code_q[idx]};
                        shadow[idx]        <= code_q[idx];
                        state              <= WRITE;
                    end else if (idx == LAST_IDX) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                WRITE: begin
                    if (idx == LAST_IDX) begin
                        bus.done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= CHECK;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hex_display_sequencer.sv
// Directed plus randomized checks of hex_display_sequencer against a digit-level
// model that tracks what each PIO should display.
module tb_hex_display_sequencer;
    localparam int N = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    hex_display_if #(.NDIGITS(N)) bus ();

    hex_display_sequencer #(.NDIGITS(N), .BLANK_CODE(7'h7F)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    always @(posedge clk) cyc++;

    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0]  m_shadow [N];
    int          exp_dig[$];
    logic [31:0] exp_dat[$];
    int          obs_dig[$];
    logic [31:0] obs_dat[$];
    int          done_cnt = 0;
    int          done_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // What each display should show and which digits must be rewritten.
    task automatic model_plan(input logic [4*N-1:0] v, input logic b, input logic f);
        logic [6:0] code;
        exp_dig.delete();
        exp_dat.delete();
        for (int i = 0; i < N; i++) begin
            if (b && i > 0 && (v >> (4*i)) == 0) code = 7'h7F;
            else                                  code = seg_tab[(v >> (4*i)) & 15];
            if (f || code != m_shadow[i]) begin
                exp_dig.push_back(i);
                exp_dat.push_back({25'b0, code});
            end
            m_shadow[i] = code;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("pio_address", {30'b0, bus.pio_address}, 32'h0);
            if (!bus.pio_write_n) begin
                check("cs_onehot", {31'b0, $onehot(bus.pio_chipselect)}, 32'h1);
                for (int d = 0; d < N; d++)
                    if (bus.pio_chipselect[d]) obs_dig.push_back(d);
                obs_dat.push_back(bus.pio_writedata);
            end else begin
                check("cs_idle", {28'b0, bus.pio_chipselect}, 32'h0);
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [4*N-1:0] v, input logic b, input logic f, output int load_cyc);
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_value    = v;
        bus.req_blank_lz = b;
        bus.req_force    = f;
        load_cyc         = cyc + 1;
        @(negedge clk);
        bus.req_valid    = 1'b0;
        check("busy_after_req", {31'b0, bus.busy}, 32'h1);
    endtask

    task automatic wait_done(input int target);
        repeat (6*N + 20) begin
            @(posedge clk);
            if (done_cnt >= target) break;
        end
        check("done_seen", done_cnt, target);
    endtask

    task automatic compare_writes(input string tag, input int ed[$], input logic [31:0] ea[$]);
        check({tag, "_nwrites"}, obs_dig.size(), ed.size());
        for (int i = 0; i < ed.size() && i < obs_dig.size(); i++) begin
            check({tag, "_digit"}, obs_dig[i], ed[i]);
            check({tag, "_data"},  obs_dat[i], ea[i]);
        end
    endtask

    task automatic run_req(input string tag, input logic [4*N-1:0] v, input logic b, input logic f);
        int load_cyc;
        int target;
        model_plan(v, b, f);
        obs_dig.delete();
        obs_dat.delete();
        target = done_cnt + 1;
        send(v, b, f, load_cyc);
        wait_done(target);
        // One CHECK per digit, one extra cycle per write, then DONE.
        check({tag, "_latency"}, done_cyc - load_cyc, N + exp_dig.size() + 1);
        compare_writes(tag, exp_dig, exp_dat);
        @(negedge clk);
        check({tag, "_busy_low"}, {31'b0, bus.busy}, 32'h0);
        check({tag, "_done_low"}, {31'b0, bus.done}, 32'h0);
    endtask

    int          first_dig[$];
    logic [31:0] first_dat[$];
    int          load1, tmp, d1, target;
    logic [15:0] prev, v;

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_value    = '0;
        bus.req_blank_lz = 1'b0;
        bus.req_force    = 1'b0;
        for (int i = 0; i < N; i++) m_shadow[i] = 7'h00;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_cs",   {28'b0, bus.pio_chipselect}, 32'h0);
        check("rst_wr_n", {31'b0, bus.pio_write_n}, 32'h1);
        check("rst_data", bus.pio_writedata, 32'h0);
        reset_n = 1'b1;

        run_req("v1234",   16'h1234, 1'b0, 1'b0);
        run_req("v1234_r", 16'h1234, 1'b0, 1'b0);
        run_req("v1235",   16'h1235, 1'b0, 1'b0);
        run_req("v0007_b", 16'h0007, 1'b1, 1'b0);
        run_req("v0000_b", 16'h0000, 1'b1, 1'b0);
        run_req("v0000_f", 16'h0000, 1'b0, 1'b1);

        // Two requests while busy: only the newest is served after the current one.
        model_plan(16'h5678, 1'b0, 1'b1);
        first_dig = exp_dig;
        first_dat = exp_dat;
        model_plan(16'hBBBB, 1'b0, 1'b0);
        obs_dig.delete();
        obs_dat.delete();
        target = done_cnt + 1;
        send(16'h5678, 1'b0, 1'b1, load1);
        send(16'hAAAA, 1'b0, 1'b0, tmp);
        send(16'hBBBB, 1'b0, 1'b0, tmp);
        wait_done(target);
        check("pend_lat1", done_cyc - load1, N + first_dig.size() + 1);
        d1 = done_cyc;
        compare_writes("pend_first", first_dig, first_dat);
        obs_dig.delete();
        obs_dat.delete();
        wait_done(target + 1);
        check("pend_lat2", done_cyc - (d1 + 2), N + exp_dig.size() + 1);
        compare_writes("pend_second", exp_dig, exp_dat);
        @(negedge clk);
        check("pend_busy_low", {31'b0, bus.busy}, 32'h0);

        // Reset in the middle of a write.
        send(16'h4321, 1'b0, 1'b1, tmp);
        repeat (20) begin
            if (!bus.pio_write_n) break;
            @(negedge clk);
        end
        check("mid_write_seen", {31'b0, bus.pio_write_n}, 32'h0);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_wr_n", {31'b0, bus.pio_write_n}, 32'h1);
        check("mid_rst_busy", {31'b0, bus.busy}, 32'h0);
        check("mid_rst_cs",   {28'b0, bus.pio_chipselect}, 32'h0);
        for (int i = 0; i < N; i++) m_shadow[i] = 7'h00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_req("v8888",   16'h8888, 1'b0, 1'b0);
        run_req("v8888_f", 16'h8888, 1'b0, 1'b1);

        prev = 16'h8888;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 3))
                0:       v = prev;
                1:       v = prev ^ (16'hF << (4 * $urandom_range(0, N - 1)));
                2:       v = 16'($urandom_range(0, 255));
                default: v = 16'($urandom);
            endcase
            run_req("rand", v, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            prev = v;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
